// File: rtl/axi4_lite_gpu_fill.sv
// ---------------------------------------------------------------------------
// axi4_lite_gpu_fill
//
// AXI4-Lite control slave with a small register file and a rectangle-fill
// engine that drives the write-only framebuffer BRAM port.
//
// Handshake rule for every AXI channel: a transfer happens on the rising
// clock edge where VALID and READY are both 1; a source holds VALID and its
// payload stable until that edge, and READY never depends on VALID.
//
// Ports
//   s_axi_ctrl_aclk / s_axi_ctrl_areset  clock, synchronous active-high reset
//   s_axi_ctrl_ar*   read address channel (addr[4:2] decoded)
//   s_axi_ctrl_r*    read data channel
//   s_axi_ctrl_aw*   write address channel (one-slot capture)
//   s_axi_ctrl_w*    write data channel with byte strobes (one-slot capture)
//   s_axi_ctrl_b*    write response channel
//   fbuf_en_wr/fbuf_wrea/fbuf_addr/fbuf_data  BRAM write port
//   dbg_state_o      fill FSM state (1 = FILL)
//
// Register map: 0x00 CTRL/STATUS, 0x04 ORIGIN, 0x08 SIZE, 0x0C COLOR,
// 0x10 PIXEL (write-only), 0x14 ID, 0x18/0x1C SLVERR.
// ---------------------------------------------------------------------------
module axi4_lite_gpu_fill #(
  parameter int unsigned AXI_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH    = 32,
  parameter int unsigned FBUF_ADDR_WIDTH   = 19,
  parameter int unsigned FBUF_DATA_WIDTH   = 8,
  parameter int unsigned FB_WIDTH          = 640,
  parameter int unsigned FB_HEIGHT         = 480,
  parameter logic [31:0] BLOCK_ID          = 32'h4650_0001
) (
  input  logic                         s_axi_ctrl_aclk,
  input  logic                         s_axi_ctrl_areset,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                         s_axi_ctrl_arvalid,
  output logic                         s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
  output logic [1:0]                   s_axi_ctrl_rresp,
  output logic                         s_axi_ctrl_rvalid,
  input  logic                         s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                         s_axi_ctrl_awvalid,
  output logic                         s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
  input  logic [3:0]                   s_axi_ctrl_wstrb,
  input  logic                         s_axi_ctrl_wvalid,
  output logic                         s_axi_ctrl_wready,
  output logic [1:0]                   s_axi_ctrl_bresp,
  output logic                         s_axi_ctrl_bvalid,
  input  logic                         s_axi_ctrl_bready,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data,
  output logic                         dbg_state_o
);

  localparam int unsigned FA = FBUF_ADDR_WIDTH;
  localparam int unsigned FD = FBUF_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_e;
  state_e state_q, state_d;

  // AXI channel state
  logic        rvalid_q, bvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic        aw_held_q, w_held_q;
  logic [2:0]  awidx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // register file
  logic [15:0]   x0_q, y0_q, w_q, h_q;
  logic [FD-1:0] color_q;
  logic          done_q;

  // single-pixel write slot and fill engine
  logic          pix_en_q;
  logic [FA-1:0] pix_addr_q;
  logic [FD-1:0] pix_data_q;
  logic [FA-1:0] fill_addr_q;
  logic [15:0]   x_cnt_q, y_cnt_q, wc_q, hc_q;

  logic busy;
  assign busy        = (state_q == ST_FILL);
  assign dbg_state_o = busy;

  // Upper/lower address bits are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_araddr[1:0],
                              s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_awaddr[1:0]};

  assign s_axi_ctrl_arready = !s_axi_ctrl_areset && !rvalid_q;
  assign s_axi_ctrl_awready = !s_axi_ctrl_areset && !aw_held_q && !bvalid_q;
  assign s_axi_ctrl_wready  = !s_axi_ctrl_areset && !w_held_q && !bvalid_q;
  assign s_axi_ctrl_rvalid  = rvalid_q;
  assign s_axi_ctrl_rdata   = rdata_q;
  assign s_axi_ctrl_rresp   = rresp_q;
  assign s_axi_ctrl_bvalid  = bvalid_q;
  assign s_axi_ctrl_bresp   = bresp_q;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------- read decode ----------------
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axi_ctrl_araddr[4:2])
      3'd0:    rd_data = {30'd0, done_q, busy};
      3'd1:    rd_data = {y0_q, x0_q};
      3'd2:    rd_data = {h_q, w_q};
      3'd3:    rd_data = 32'(color_q);
      3'd4:    rd_data = '0;
      3'd5:    rd_data = BLOCK_ID;
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  // ---------------- geometry helpers ----------------
  // Clipped extents and the start address are computed once at command time;
  // the fill loop itself only adds.
  logic [15:0]   x_room, y_room, wc_calc, hc_calc;
  logic          x_in, y_in;
  logic [FA-1:0] base_addr, row_step;
  always_comb begin
    x_in      = (32'(x0_q) < 32'(FB_WIDTH));
    y_in      = (32'(y0_q) < 32'(FB_HEIGHT));
    x_room    = 16'(32'(FB_WIDTH) - 32'(x0_q));
    y_room    = 16'(32'(FB_HEIGHT) - 32'(y0_q));
    wc_calc   = !x_in ? 16'd0 : ((w_q < x_room) ? w_q : x_room);
    hc_calc   = !y_in ? 16'd0 : ((h_q < y_room) ? h_q : y_room);
    base_addr = FA'(32'(y0_q) * 32'(FB_WIDTH) + 32'(x0_q));
    // jump from the last pixel of a row to the first pixel of the next one
    row_step  = FA'(32'(FB_WIDTH) - 32'(wc_q) + 32'd1);
  end

  // ---------------- write commit decode ----------------
  logic          commit, cmd_start, cmd_clear;
  logic          wr_err, upd_origin, upd_size, upd_color, clr_done;
  logic          start_fill, start_empty, pix_go;
  logic [31:0]   origin_new, size_new, color_merged;
  always_comb begin
    commit       = aw_held_q && w_held_q;
    cmd_start    = wstrb_q[0] && wdata_q[0];
    cmd_clear    = wstrb_q[0] && wdata_q[1];
    origin_new   = merge_strb({y0_q, x0_q}, wdata_q, wstrb_q);
    size_new     = merge_strb({h_q, w_q}, wdata_q, wstrb_q);
    color_merged = merge_strb(32'(color_q), wdata_q, wstrb_q);
    wr_err       = 1'b0;
    upd_origin   = 1'b0;
    upd_size     = 1'b0;
    upd_color    = 1'b0;
    clr_done     = 1'b0;
    start_fill   = 1'b0;
    start_empty  = 1'b0;
    pix_go       = 1'b0;
    if (commit) begin
      case (awidx_q)
        3'd0: begin
          if (busy && cmd_start) begin
            wr_err = 1'b1;
          end else begin
            clr_done = cmd_clear;
            if (cmd_start) begin
              if (wc_calc == 16'd0 || hc_calc == 16'd0) start_empty = 1'b1;
              else                                      start_fill  = 1'b1;
            end
          end
        end
        3'd1: if (busy) wr_err = 1'b1; else upd_origin = 1'b1;
        3'd2: if (busy) wr_err = 1'b1; else upd_size = 1'b1;
        3'd3: if (busy) wr_err = 1'b1; else upd_color = 1'b1;
        3'd4: begin
          if (busy) wr_err = 1'b1;
          else if (wstrb_q[0]) begin
            if (x_in && y_in) pix_go = 1'b1;
            else              wr_err = 1'b1;
          end
        end
        3'd5:    ;  // ID is read-only; writes are ignored
        default: wr_err = 1'b1;
      endcase
    end
  end

  // ---------------- fill FSM ----------------
  logic last_col, last_pix;
  assign last_col = (x_cnt_q == wc_q - 16'd1);
  assign last_pix = last_col && (y_cnt_q == hc_q - 16'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_fill) state_d = ST_FILL;
      ST_FILL: if (last_pix)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // ---------------- BRAM port ----------------
  // Enable is gated by reset so an aborted fill never writes in the reset cycle.
  always_comb begin
    fbuf_en_wr = 1'b0;
    fbuf_addr  = '0;
    fbuf_data  = '0;
    if (busy) begin
      fbuf_en_wr = 1'b1;
      fbuf_addr  = fill_addr_q;
      fbuf_data  = color_q;
    end else if (pix_en_q) begin
      fbuf_en_wr = 1'b1;
      fbuf_addr  = pix_addr_q;
      fbuf_data  = pix_data_q;
    end
    if (s_axi_ctrl_areset) begin
      fbuf_en_wr = 1'b0;
      fbuf_addr  = '0;
      fbuf_data  = '0;
    end
  end
  assign fbuf_wrea = fbuf_en_wr;

  // ---------------- datapath registers ----------------
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awidx_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      done_q      <= 1'b0;
      pix_en_q    <= 1'b0;
      pix_addr_q  <= '0;
      pix_data_q  <= '0;
      fill_addr_q <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      wc_q        <= '0;
      hc_q        <= '0;
    end else begin
      // read channel
      if (s_axi_ctrl_arvalid && s_axi_ctrl_arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi_ctrl_rready) begin
        rvalid_q <= 1'b0;
      end

      // write capture slots
      if (s_axi_ctrl_awvalid && s_axi_ctrl_awready) begin
        aw_held_q <= 1'b1;
        awidx_q   <= s_axi_ctrl_awaddr[4:2];
      end
      if (s_axi_ctrl_wvalid && s_axi_ctrl_wready) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi_ctrl_wdata;
        wstrb_q  <= s_axi_ctrl_wstrb;
      end

      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axi_ctrl_bready) begin
        bvalid_q <= 1'b0;
      end

      if (upd_origin) {y0_q, x0_q} <= origin_new;
      if (upd_size)   {h_q, w_q}   <= size_new;
      if (upd_color)  color_q      <= FD'(color_merged);

      // clear first so a start or a finishing fill in the same cycle wins
      if (clr_done)              done_q <= 1'b0;
      if (start_empty)           done_q <= 1'b1;
      if (busy && last_pix)      done_q <= 1'b1;

      pix_en_q <= pix_go;
      if (pix_go) begin
        pix_addr_q <= base_addr;
        pix_data_q <= FD'(wdata_q);
      end

      if (start_fill) begin
        fill_addr_q <= base_addr;
        x_cnt_q     <= '0;
        y_cnt_q     <= '0;
        wc_q        <= wc_calc;
        hc_q        <= hc_calc;
      end else if (busy) begin
        if (last_col) begin
          x_cnt_q     <= '0;
          y_cnt_q     <= y_cnt_q + 16'd1;
          fill_addr_q <= fill_addr_q + row_step;
        end else begin
          x_cnt_q     <= x_cnt_q + 16'd1;
          fill_addr_q <= fill_addr_q + FA'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_gpu_fill.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_gpu_fill
//
// Directed bench for axi4_lite_gpu_fill: AXI-Lite driver tasks, a BRAM-write
// scoreboard fed with hand-computed {addr,data} pairs, and a final report.
// ---------------------------------------------------------------------------
module tb_axi4_lite_gpu_fill;

  localparam int FA = 19;
  localparam int FD = 8;
  localparam int EW = FA + FD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        fbuf_en_wr, fbuf_wrea, dbg_state;
  logic [FA-1:0] fbuf_addr;
  logic [FD-1:0] fbuf_data;

  axi4_lite_gpu_fill dut (
    .s_axi_ctrl_aclk   (clk),
    .s_axi_ctrl_areset (areset),
    .s_axi_ctrl_araddr (araddr),
    .s_axi_ctrl_arvalid(arvalid),
    .s_axi_ctrl_arready(arready),
    .s_axi_ctrl_rdata  (rdata),
    .s_axi_ctrl_rresp  (rresp),
    .s_axi_ctrl_rvalid (rvalid),
    .s_axi_ctrl_rready (rready),
    .s_axi_ctrl_awaddr (awaddr),
    .s_axi_ctrl_awvalid(awvalid),
    .s_axi_ctrl_awready(awready),
    .s_axi_ctrl_wdata  (wdata),
    .s_axi_ctrl_wstrb  (wstrb),
    .s_axi_ctrl_wvalid (wvalid),
    .s_axi_ctrl_wready (wready),
    .s_axi_ctrl_bresp  (bresp),
    .s_axi_ctrl_bvalid (bvalid),
    .s_axi_ctrl_bready (bready),
    .fbuf_en_wr        (fbuf_en_wr),
    .fbuf_wrea         (fbuf_wrea),
    .fbuf_addr         (fbuf_addr),
    .fbuf_data         (fbuf_data),
    .dbg_state_o       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int wr_cnt = 0;
  int fill_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input int a, input int d);
    return {FA'(a), FD'(d)};
  endfunction

  // every BRAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (dbg_state) fill_cycles++;
    if (fbuf_en_wr) begin
      wr_cnt++;
      chk("fbuf_exp_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("fbuf_wr", 32'({fbuf_wrea, fbuf_addr, fbuf_data}), 32'({1'b1, exp_q.pop_front()}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    int cyc = 0;
    bit aw_sent, aw_hs, w_hs, b_hs, b_done = 0;
    @(negedge clk);
    wvalid = 1'b1; wdata = data; wstrb = strb; awaddr = addr;
    bready = 1'b1;
    aw_sent = (w_lead == 0);
    awvalid = aw_sent;
    resp = 2'b11;
    while (!b_done && cyc < 40) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (b_hs) resp = bresp;
      @(negedge clk);
      cyc++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid = 1'b0;
      if (b_hs)  b_done = 1;
      if (!aw_sent && cyc >= w_lead) begin
        awvalid = 1'b1;
        aw_sent = 1;
      end
    end
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_complete", 32'(b_done), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    bit ar_hs, r_hs, r_done = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    data = '0; resp = 2'b11;
    while (!r_done && cyc < 40) begin
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (r_hs) begin
        data = rdata;
        resp = rresp;
      end
      @(negedge clk);
      cyc++;
      if (ar_hs) arvalid = 1'b0;
      if (r_hs)  r_done = 1;
    end
    rready = 1'b0; arvalid = 1'b0;
    chk("rd_complete", 32'(r_done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int s_fill, s_wr, n, bv;

    // reset: every ready/valid and the BRAM enable low
    repeat (4) begin
      @(negedge clk);
      chk("reset_hs", 32'({arready, awready, wready, rvalid, bvalid, fbuf_en_wr}), 32'd0);
    end
    areset = 1'b0;

    axi_read(32'h14, d, r);
    chk("id_data", d, 32'h4650_0001);
    chk("id_resp", 32'(r), 32'd0);
    axi_read(32'h18, d, r);
    chk("rd_0x18_resp", 32'(r), 32'd2);
    axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0, r);
    chk("wr_0x1c_resp", 32'(r), 32'd2);

    // W three cycles ahead of AW, only the low two byte lanes
    axi_write(32'h04, 32'h0002_0003, 4'b0011, 3, r);
    chk("w_first_resp", 32'(r), 32'd0);
    bv = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid) bv++;
    end
    chk("bvalid_once", 32'(bv), 32'd0);
    axi_read(32'h04, d, r);
    chk("origin_strb", d, 32'h0000_0003);

    // clipped fill at the right edge: 638..639 on rows 0 and 1
    axi_write(32'h04, 32'h0000_027E, 4'hF, 0, r);
    axi_write(32'h08, 32'h0002_0004, 4'hF, 0, r);
    axi_write(32'h0C, 32'hFFFF_FF5A, 4'hF, 0, r);
    axi_read(32'h0C, d, r);
    chk("color_upper0", d, 32'h0000_005A);
    exp_q.push_back(pk(638, 8'h5A));
    exp_q.push_back(pk(639, 8'h5A));
    exp_q.push_back(pk(1278, 8'h5A));
    exp_q.push_back(pk(1279, 8'h5A));
    s_fill = fill_cycles;
    axi_write(32'h00, 32'h1, 4'hF, 0, r);
    chk("fill1_start_resp", 32'(r), 32'd0);
    idle(10);
    chk("fill1_busy_cycles", 32'(fill_cycles - s_fill), 32'd4);
    chk("fill1_all_written", 32'(exp_q.size()), 32'd0);
    axi_read(32'h00, d, r);
    chk("fill1_status", d, 32'h2);
    axi_write(32'h00, 32'h2, 4'hF, 0, r);
    axi_read(32'h00, d, r);
    chk("done_clear", d, 32'h0);

    // start bit without byte lane 0 is a no-op
    s_fill = fill_cycles;
    axi_write(32'h00, 32'h1, 4'b1110, 0, r);
    chk("ctrl_nostrb_resp", 32'(r), 32'd0);
    idle(4);
    chk("ctrl_nostrb_nofill", 32'(fill_cycles - s_fill), 32'd0);

    // 8x4 fill at the origin, with traffic while busy
    axi_write(32'h04, 32'h0, 4'hF, 0, r);
    axi_write(32'h08, 32'h0004_0008, 4'hF, 0, r);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        exp_q.push_back(pk(y * 640 + x, 8'h5A));
    s_fill = fill_cycles;
    axi_write(32'h00, 32'h1, 4'hF, 0, r);
    axi_write(32'h0C, 32'h33, 4'hF, 0, r);
    chk("busy_color_resp", 32'(r), 32'd2);
    axi_read(32'h00, d, r);
    chk("busy_status", d, 32'h1);
    axi_write(32'h00, 32'h2, 4'hF, 0, r);
    chk("busy_clear_resp", 32'(r), 32'd0);
    idle(40);
    axi_read(32'h00, d, r);
    chk("fill2_status", d, 32'h2);
    axi_read(32'h0C, d, r);
    chk("fill2_color_kept", d, 32'h5A);
    chk("fill2_busy_cycles", 32'(fill_cycles - s_fill), 32'd32);
    chk("fill2_all_written", 32'(exp_q.size()), 32'd0);

    // PIXEL writes: out-of-range X and Y, then two in-range pixels
    s_wr = wr_cnt;
    axi_write(32'h04, 32'h0000_0280, 4'hF, 0, r);
    axi_write(32'h10, 32'hFF, 4'hF, 0, r);
    chk("pix_x640_resp", 32'(r), 32'd2);
    axi_write(32'h04, 32'h01E0_0000, 4'hF, 0, r);
    axi_write(32'h10, 32'hFF, 4'hF, 0, r);
    chk("pix_y480_resp", 32'(r), 32'd2);
    idle(3);
    chk("pix_oob_nowrite", 32'(wr_cnt - s_wr), 32'd0);
    axi_write(32'h04, 32'h0001_0005, 4'hF, 0, r);
    exp_q.push_back(pk(645, 8'hFF));
    axi_write(32'h10, 32'hFF, 4'hF, 0, r);
    chk("pix_5_1_resp", 32'(r), 32'd0);
    axi_write(32'h04, 32'h01DF_027F, 4'hF, 0, r);
    exp_q.push_back(pk(307199, 8'h11));
    axi_write(32'h10, 32'h11, 4'hF, 0, r);
    chk("pix_corner_resp", 32'(r), 32'd0);
    idle(3);
    chk("pix_write_count", 32'(wr_cnt - s_wr), 32'd2);
    chk("pix_all_written", 32'(exp_q.size()), 32'd0);
    axi_read(32'h10, d, r);
    chk("pixel_reads_0", d, 32'h0);

    // reset in the middle of a 10x10 fill, on its third pixel
    axi_write(32'h04, 32'h0, 4'hF, 0, r);
    axi_write(32'h08, 32'h000A_000A, 4'hF, 0, r);
    exp_q.push_back(pk(0, 8'h5A));
    exp_q.push_back(pk(1, 8'h5A));
    exp_q.push_back(pk(2, 8'h5A));
    axi_write(32'h00, 32'h1, 4'hF, 0, r);
    n = 0;
    while (!(fbuf_en_wr && fbuf_addr == FA'(2)) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("third_pixel_seen", 32'(n < 30), 32'd1);
    #1 areset = 1'b1;
    @(negedge clk);
    chk("abort_en", 32'(fbuf_en_wr), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    areset = 1'b0;
    s_wr = wr_cnt;
    axi_read(32'h00, d, r);
    chk("abort_status", d, 32'h0);
    axi_read(32'h08, d, r);
    chk("abort_size_reset", d, 32'h0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);

    // empty fill: DONE without any BRAM writes
    axi_write(32'h08, 32'h000A_0000, 4'hF, 0, r);
    axi_write(32'h00, 32'h1, 4'hF, 0, r);
    chk("empty_start_resp", 32'(r), 32'd0);
    axi_read(32'h00, d, r);
    chk("empty_status", d, 32'h2);
    idle(3);
    chk("empty_nowrite", 32'(wr_cnt - s_wr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
